mem_access_unit: RTL

Load/store front end that sits directly upstream of the byte-addressable `mem` block and drives its `addr`, `wData`, `mWrite`, `mByte` and `mRead` inputs. It accepts one load/store request at a time from the pipeline over a valid/ready handshake and range-checks the address. It splits unaligned word accesses into two byte accesses, then returns a single registered response with zero- or sign-extended load data. Word byte order is big-endian: word at A = {mem[A], mem[A+1]}.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mau_extend.sv | 12 +
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the load/store front end.
package mem_pkg;

  localparam int DEF_MEM_BYTES = 56;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_ACC1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Accept edge to resp_valid, in cycles.
  localparam int LAT_ERR          = 1;
  localparam int LAT_STORE        = 2;
  localparam int LAT_LOAD         = 3;
  localparam int LAT_UNALIGN_ST   = 3;
  localparam int LAT_UNALIGN_LD   = 5;

endpackage

// File: rtl/mau_extend.sv
// Byte merge and zero/sign extension of load data.
module mau_extend (
  input  logic [7:0]  byte0,
  input  logic [7:0]  byte1,
  input  logic        is_byte,
  input  logic        is_signed,
  output logic [15:0] result
);

  assign result = is_byte ? {{8{byte0[7] & is_signed}}, byte0} : {byte0, byte1};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the byte-addressable mem block (big-endian words).
// MAU_UNALIGNED_EN: when defined, unaligned word accesses are split into two byte accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] addr,
  output logic [15:0] wData,
  output logic        mWrite,
  output logic        mByte,
  output logic        mRead,
  input  logic [15:0] data
);

  localparam logic [16:0] LIMIT = 17'(MEM_BYTES);

  state_t      state_reg;
  logic        wr_reg;
  logic        byte_reg;
  logic        sgn_reg;
  logic [16:0] addr_ext;
  logic        range_err;
  logic        unaligned;
  logic        req_err;
  logic        split_req;
  logic [7:0]  ext_b0;
  logic [15:0] ext_result;

  // Extend to 17 bits so A+1 can never wrap back into range.
  assign addr_ext  = {1'b0, req_addr};
  assign range_err = req_byte ? (addr_ext >= LIMIT) : ((addr_ext + 17'd1) >= LIMIT);
  assign unaligned = !req_byte && req_addr[0];

`ifdef MAU_UNALIGNED_EN
  logic       split_reg;
  logic [7:0] wdata_lo_reg;
  logic [7:0] byte0_reg;

  assign req_err   = range_err;
  assign split_req = unaligned;
  assign ext_b0    = (state_reg == ST_WAIT1) ? byte0_reg
                   : (byte_reg ? data[7:0] : data[15:8]);
`else
  assign req_err   = range_err || unaligned;
  assign split_req = 1'b0;
  assign ext_b0    = byte_reg ? data[7:0] : data[15:8];
`endif

  mau_extend u_extend (
    .byte0     (ext_b0),
    .byte1     (data[7:0]),
    .is_byte   (byte_reg),
    .is_signed (sgn_reg),
    .result    (ext_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 16'h0000;
      addr       <= 16'h0000;
      wData      <= 16'h0000;
      mWrite     <= 1'b0;
      mByte      <= 1'b0;
      mRead      <= 1'b0;
      wr_reg     <= 1'b0;
      byte_reg   <= 1'b0;
      sgn_reg    <= 1'b0;
`ifdef MAU_UNALIGNED_EN
      split_reg    <= 1'b0;
      wdata_lo_reg <= 8'h00;
      byte0_reg    <= 8'h00;
`endif
    end else begin
      resp_valid <= 1'b0;
      mWrite     <= 1'b0;
      mRead      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wr_reg    <= req_write;
            byte_reg  <= req_byte;
            sgn_reg   <= req_signed;
            if (req_err) begin
              state_reg  <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 16'h0000;
            end else begin
              state_reg <= ST_ACC0;
              addr      <= req_addr;
              mByte     <= req_byte || split_req;
              wData     <= split_req ? {8'h00, req_wdata[15:8]} : req_wdata;
              mWrite    <= req_write;
              mRead     <= !req_write;
`ifdef MAU_UNALIGNED_EN
              split_reg    <= split_req;
              wdata_lo_reg <= req_wdata[7:0];
`endif
            end
          end
        end
        ST_ACC0: begin
          if (!wr_reg) begin
            state_reg <= ST_WAIT0;
`ifdef MAU_UNALIGNED_EN
          end else if (split_reg) begin
            state_reg <= ST_ACC1;
            addr      <= addr + 16'd1;
            wData     <= {8'h00, wdata_lo_reg};
            mWrite    <= 1'b1;
`endif
          end else begin
            state_reg  <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 16'h0000;
          end
        end
        ST_WAIT0: begin
`ifdef MAU_UNALIGNED_EN
          if (split_reg) begin
            byte0_reg <= data[7:0];
            state_reg <= ST_ACC1;
            addr      <= addr + 16'd1;
            mRead     <= 1'b1;
          end else begin
            state_reg  <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ext_result;
          end
`else
          state_reg  <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ext_result;
`endif
        end
`ifdef MAU_UNALIGNED_EN
        ST_ACC1: begin
          if (wr_reg) begin
            state_reg  <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 16'h0000;
          end else begin
            state_reg <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          state_reg  <= ST_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= ext_result;
        end
`endif
        ST_RESP: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
